// File: rtl/ysyx_25030081_mem_pkg.sv
// ysyx_25030081_mem_pkg: shared types and constants for the memory arbiter.
// Revision: 1.0
`default_nettype none

package ysyx_25030081_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  localparam int DEFAULT_TIMEOUT = 255;

endpackage

`default_nettype wire

// File: rtl/ysyx_25030081_mem_arb_if.sv
// ysyx_25030081_mem_arb_if: IFU/LSU request-response and memory bus bundle.
// Revision: 1.0
`default_nettype none

interface ysyx_25030081_mem_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    ifu_req_valid;
  logic                    ifu_req_ready;
  logic [ADDR_WIDTH-1:0]   ifu_addr;
  logic                    ifu_resp_valid;
  logic [DATA_WIDTH-1:0]   ifu_rdata;
  logic                    ifu_resp_err;

  logic                    lsu_req_valid;
  logic                    lsu_req_ready;
  logic [ADDR_WIDTH-1:0]   lsu_addr;
  logic                    lsu_wen;
  logic [DATA_WIDTH-1:0]   lsu_wdata;
  logic [DATA_WIDTH/8-1:0] lsu_wmask;
  logic                    lsu_resp_valid;
  logic [DATA_WIDTH-1:0]   lsu_rdata;
  logic                    lsu_resp_err;

  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_wen;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wmask;
  logic                    mem_resp_valid;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_resp_err;

  // The arbiter itself.
  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );

  // Everything around the arbiter: requesters plus memory.
  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_25030081_rr_arb2.sv
// ysyx_25030081_rr_arb2: combinational 2-way round-robin picker.
// Revision: 1.0
`default_nettype none

module ysyx_25030081_rr_arb2
  import ysyx_25030081_mem_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant,
  output logic       o_grant_id
);

  always_comb begin
    o_grant_id = REQ_IFU;
    o_grant    = 2'b00;
    case (i_valid)
      2'b01:   o_grant_id = REQ_IFU;
      2'b10:   o_grant_id = REQ_LSU;
      2'b11:   o_grant_id = ~i_last_grant;
      default: o_grant_id = REQ_IFU;
    endcase
    if (|i_valid) begin
      o_grant = (o_grant_id == REQ_LSU) ? 2'b10 : 2'b01;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_25030081_mem_arb.sv
// ysyx_25030081_mem_arb: shares one memory port between IFU and LSU with timeout.
// Revision: 1.0
`default_nettype none

module ysyx_25030081_mem_arb
  import ysyx_25030081_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_25030081_mem_arb_if.slave bus
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam int              MASK_W  = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(TIMEOUT);

  state_t                  r_state, w_state_nxt;
  logic                    r_owner, r_last_grant;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_mem_req_valid, r_mem_wen;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [MASK_W-1:0]       r_mem_wmask;

  logic [1:0]              w_req_valid, w_grant;
  logic                    w_grant_id, w_hs, w_resp_fire, w_timeout;
  logic                    w_ifu_pulse, w_lsu_pulse;

  assign w_req_valid = {bus.lsu_req_valid, bus.ifu_req_valid};

  ysyx_25030081_rr_arb2 u_rr_arb2 (
    .i_valid      (w_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_id   (w_grant_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    w_resp_fire = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: if (|w_req_valid) begin
        w_hs        = 1'b1;
        w_state_nxt = ISSUE;
      end
      ISSUE: if (bus.mem_req_ready) w_state_nxt = WAIT;
      WAIT: begin
        // A response landing in the limit cycle takes priority over the timeout.
        if (bus.mem_resp_valid) begin
          w_resp_fire = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == C_LIMIT) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner         <= REQ_IFU;
      r_last_grant    <= REQ_IFU;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wen       <= 1'b0;
      r_mem_wdata     <= '0;
      r_mem_wmask     <= '0;
    end else if (w_hs) begin
      r_owner         <= w_grant_id;
      r_last_grant    <= w_grant_id;
      r_mem_req_valid <= 1'b1;
      if (w_grant_id == REQ_LSU) begin
        r_mem_addr  <= bus.lsu_addr;
        r_mem_wen   <= bus.lsu_wen;
        r_mem_wdata <= bus.lsu_wdata;
        r_mem_wmask <= bus.lsu_wmask;
      end else begin
        r_mem_addr  <= bus.ifu_addr;
        r_mem_wen   <= 1'b0;
        r_mem_wdata <= '0;
        r_mem_wmask <= '0;
      end
    end else if (r_state == ISSUE && bus.mem_req_ready) begin
      r_mem_req_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        r_cnt <= '0;
    else if (r_state != WAIT)                       r_cnt <= '0;
    else if (w_state_nxt == WAIT)                   r_cnt <= r_cnt + 1'b1;
  end

  assign w_ifu_pulse = ~rst & (w_resp_fire | w_timeout) & (r_owner == REQ_IFU);
  assign w_lsu_pulse = ~rst & (w_resp_fire | w_timeout) & (r_owner == REQ_LSU);

  assign bus.ifu_req_ready  = ~rst & (r_state == IDLE) & w_grant[0];
  assign bus.lsu_req_ready  = ~rst & (r_state == IDLE) & w_grant[1];

  assign bus.ifu_resp_valid = w_ifu_pulse;
  assign bus.ifu_rdata      = (w_ifu_pulse & w_resp_fire) ? bus.mem_rdata : '0;
  assign bus.ifu_resp_err   = w_ifu_pulse & (w_timeout | bus.mem_resp_err);

  // Store responses never forward memory read data.
  assign bus.lsu_resp_valid = w_lsu_pulse;
  assign bus.lsu_rdata      = (w_lsu_pulse & w_resp_fire & ~r_mem_wen) ? bus.mem_rdata : '0;
  assign bus.lsu_resp_err   = w_lsu_pulse & (w_timeout | bus.mem_resp_err);

  assign bus.mem_req_valid  = r_mem_req_valid;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_wen        = r_mem_wen;
  assign bus.mem_wdata      = r_mem_wdata;
  assign bus.mem_wmask      = r_mem_wmask;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25030081_mem_arb.sv
// tb_ysyx_25030081_mem_arb: directed vectors plus corner sequences for the memory arbiter.
// Revision: 1.0
`default_nettype none

module tb_ysyx_25030081_mem_arb;

  typedef struct packed {
    logic        ifu_v;
    logic        lsu_v;
    logic [31:0] ifu_addr;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic [31:0] m_rdata;
    logic        m_err;
    logic        exp_lsu;
    logic [31:0] exp_addr;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs [7];

  always #5 clk = ~clk;

  ysyx_25030081_mem_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ysyx_25030081_mem_arb #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ifu_req_valid  = 1'b0;
    bus.ifu_addr       = '0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_addr       = '0;
    bus.lsu_wen        = 1'b0;
    bus.lsu_wdata      = '0;
    bus.lsu_wmask      = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    bus.mem_resp_err   = 1'b0;
  endtask

  task automatic drive_req(input vec_t v);
    bus.ifu_req_valid = v.ifu_v;
    bus.ifu_addr      = v.ifu_addr;
    bus.lsu_req_valid = v.lsu_v;
    bus.lsu_addr      = v.lsu_addr;
    bus.lsu_wen       = v.lsu_wen;
    bus.lsu_wdata     = v.lsu_wdata;
    bus.lsu_wmask     = v.lsu_wmask;
  endtask

  // Full transaction starting in IDLE: grant, one ISSUE cycle, response in first WAIT cycle.
  task automatic apply(input int idx, input vec_t v);
    drive_req(v);
    #1;
    chk($sformatf("v%0d ifu_ready", idx), 32'(bus.ifu_req_ready), 32'(!v.exp_lsu));
    chk($sformatf("v%0d lsu_ready", idx), 32'(bus.lsu_req_ready), 32'(v.exp_lsu));
    tick();
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.ifu_addr      = 32'hFFFF_FFFF;
    bus.lsu_addr      = 32'hFFFF_FFFF;
    bus.lsu_wdata     = 32'hFFFF_FFFF;
    #1;
    chk($sformatf("v%0d mem_req_valid", idx), 32'(bus.mem_req_valid), 32'd1);
    chk($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.exp_addr);
    chk($sformatf("v%0d mem_wen", idx), 32'(bus.mem_wen), 32'(v.exp_wen));
    chk($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.exp_wdata);
    chk($sformatf("v%0d mem_wmask", idx), 32'(bus.mem_wmask), 32'(v.exp_wmask));
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = v.m_rdata;
    bus.mem_resp_err   = v.m_err;
    #1;
    chk($sformatf("v%0d mem_req_valid_wait", idx), 32'(bus.mem_req_valid), 32'd0);
    chk($sformatf("v%0d ifu_resp_valid", idx), 32'(bus.ifu_resp_valid), 32'(!v.exp_lsu));
    chk($sformatf("v%0d lsu_resp_valid", idx), 32'(bus.lsu_resp_valid), 32'(v.exp_lsu));
    chk($sformatf("v%0d ifu_rdata", idx), bus.ifu_rdata, v.exp_lsu ? 32'd0 : v.exp_rdata);
    chk($sformatf("v%0d lsu_rdata", idx), bus.lsu_rdata, v.exp_lsu ? v.exp_rdata : 32'd0);
    chk($sformatf("v%0d ifu_err", idx), 32'(bus.ifu_resp_err), v.exp_lsu ? 32'd0 : 32'(v.exp_err));
    chk($sformatf("v%0d lsu_err", idx), 32'(bus.lsu_resp_err), v.exp_lsu ? 32'(v.exp_err) : 32'd0);
    tick();
    clear_inputs();
    #1;
    chk($sformatf("v%0d idle_no_resp", idx), 32'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 32'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 1'b1, 32'h8000_0000, 32'h8000_2000, 1'b0, 32'h1111_1111, 4'hF, 32'hCAFE_F00D, 1'b0,
                1'b1, 32'h8000_2000, 1'b0, 32'h1111_1111, 4'hF, 32'hCAFE_F00D, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h8000_0004, 32'h8000_2004, 1'b1, 32'h55AA_55AA, 4'h3, 32'h9999_9999, 1'b0,
                1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h9999_9999, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0010_0073, 1'b0,
                1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0010_0073, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 32'h0, 32'h8000_1004, 1'b1, 32'hA5A5_A5A5, 4'h5, 32'hFFFF_FFFF, 1'b0,
                1'b1, 32'h8000_1004, 1'b1, 32'hA5A5_A5A5, 4'h5, 32'h0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h0, 32'h8000_3000, 1'b0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b1,
                1'b1, 32'h8000_3000, 1'b0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 32'h8000_000C, 32'h8000_3004, 1'b0, 32'h0, 4'h0, 32'h1357_9BDF, 1'b1,
                1'b0, 32'h8000_000C, 1'b0, 32'h0, 4'h0, 32'h1357_9BDF, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'h8000_0010, 32'h8000_1008, 1'b1, 32'h0000_FFFF, 4'hC, 32'h1212_1212, 1'b0,
                1'b1, 32'h8000_1008, 1'b1, 32'h0000_FFFF, 4'hC, 32'h0, 1'b0};

    // Reset state: requests pending but nothing may be acknowledged.
    clear_inputs();
    rst = 1'b1;
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    tick();
    tick();
    chk("rst ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
    chk("rst lsu_ready", 32'(bus.lsu_req_ready), 32'd0);
    chk("rst mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    chk("rst resp", 32'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 32'd0);
    rst = 1'b0;
    clear_inputs();
    tick();

    for (int i = 0; i < 7; i++) apply(i, vecs[i]);

    // Store held in ISSUE by a stalled memory.
    v = '0;
    v.lsu_v = 1'b1; v.lsu_addr = 32'h8000_1000; v.lsu_wen = 1'b1;
    v.lsu_wdata = 32'hDEAD_BEEF; v.lsu_wmask = 4'hF;
    drive_req(v);
    #1;
    chk("stall lsu_ready", 32'(bus.lsu_req_ready), 32'd1);
    tick();
    clear_inputs();
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
      chk("stall mem_addr", bus.mem_addr, 32'h8000_1000);
      chk("stall mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      chk("stall mem_wmask", 32'(bus.mem_wmask), 32'hF);
      chk("stall mem_wen", 32'(bus.mem_wen), 32'd1);
      tick();
    end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'hAAAA_AAAA;
    #1;
    chk("stall lsu_resp_valid", 32'(bus.lsu_resp_valid), 32'd1);
    chk("stall lsu_rdata", bus.lsu_rdata, 32'd0);
    chk("stall ifu_resp_valid", 32'(bus.ifu_resp_valid), 32'd0);
    tick();
    clear_inputs();

    // Timeout: no response, error in the 5th WAIT cycle, later stale response ignored.
    v = '0;
    v.lsu_v = 1'b1; v.lsu_addr = 32'h8000_4000;
    drive_req(v);
    tick();
    clear_inputs();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("to wait%0d lsu_resp_valid", i), 32'(bus.lsu_resp_valid), 32'd0);
      tick();
    end
    #1;
    chk("to lsu_resp_valid", 32'(bus.lsu_resp_valid), 32'd1);
    chk("to lsu_resp_err", 32'(bus.lsu_resp_err), 32'd1);
    chk("to lsu_rdata", bus.lsu_rdata, 32'd0);
    chk("to ifu_resp_valid", 32'(bus.ifu_resp_valid), 32'd0);
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h7777_7777;
    #1;
    chk("stale resp", 32'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 32'd0);
    chk("stale lsu_rdata", bus.lsu_rdata, 32'd0);
    tick();
    clear_inputs();

    // Response coincident with the timeout cycle wins.
    v = '0;
    v.ifu_v = 1'b1; v.ifu_addr = 32'h8000_0010;
    drive_req(v);
    tick();
    clear_inputs();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h1234_5678;
    #1;
    chk("edge ifu_resp_valid", 32'(bus.ifu_resp_valid), 32'd1);
    chk("edge ifu_resp_err", 32'(bus.ifu_resp_err), 32'd0);
    chk("edge ifu_rdata", bus.ifu_rdata, 32'h1234_5678);
    tick();
    clear_inputs();

    // Reset during WAIT of an LSU store.
    v = '0;
    v.lsu_v = 1'b1; v.lsu_addr = 32'h8000_5000; v.lsu_wen = 1'b1;
    v.lsu_wdata = 32'hFEED_FACE; v.lsu_wmask = 4'hF;
    drive_req(v);
    tick();
    clear_inputs();
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    rst = 1'b1;
    bus.ifu_req_valid  = 1'b1;
    bus.lsu_req_valid  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata      = 32'h5555_5555;
    #1;
    chk("rstw ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
    chk("rstw lsu_ready", 32'(bus.lsu_req_ready), 32'd0);
    chk("rstw resp", 32'({bus.ifu_resp_valid, bus.lsu_resp_valid}), 32'd0);
    chk("rstw lsu_rdata", bus.lsu_rdata, 32'd0);
    chk("rstw mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    chk("rstw mem_addr", bus.mem_addr, 32'd0);
    chk("rstw mem_wdata", bus.mem_wdata, 32'd0);
    chk("rstw mem_wen_wmask", 32'({bus.mem_wen, bus.mem_wmask}), 32'd0);
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();

    // After reset the tie goes to LSU again, then alternates to IFU.
    v = '{1'b1, 1'b1, 32'h8000_0040, 32'h8000_5004, 1'b0, 32'h0, 4'h0, 32'h2468_ACE0, 1'b0,
          1'b1, 32'h8000_5004, 1'b0, 32'h0, 4'h0, 32'h2468_ACE0, 1'b0};
    apply(7, v);
    v = '{1'b1, 1'b1, 32'h8000_0044, 32'h8000_5008, 1'b0, 32'h0, 4'h0, 32'h3141_5926, 1'b0,
          1'b0, 32'h8000_0044, 1'b0, 32'h0, 4'h0, 32'h3141_5926, 1'b0};
    apply(8, v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
